// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, requests instruction words, hands them to decode.
// Optional FETCH_BRANCH_EN macro enables branch redirect; default build is sequential only.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   o_pc                   architectural PC (registered)
//   o_imem_req/o_imem_addr instruction memory read request and address
//   i_imem_ack/i_imem_data read data return
//   o_inst/o_inst_valid    instruction to decode, i_inst_ready accepts it
//   i_branch_valid/target  redirect pulse and target (used with FETCH_BRANCH_EN)
//   i_halt, o_halted       stop request and halted status
module fetch_sequencer #(
   parameter int PC_BITS        = 8,
   parameter int INST_MEM_DEPTH = 64,
   parameter int INST_BITS      = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   output logic [PC_BITS-1:0]   o_pc,
   output logic                 o_imem_req,
   output logic [PC_BITS-1:0]   o_imem_addr,
   input  logic                 i_imem_ack,
   input  logic [INST_BITS-1:0] i_imem_data,
   output logic [INST_BITS-1:0] o_inst,
   output logic                 o_inst_valid,
   input  logic                 i_inst_ready,
   input  logic                 i_branch_valid,
   input  logic [PC_BITS-1:0]   i_branch_target,
   input  logic                 i_halt,
   output logic                 o_halted
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_HALT
   } state_t;

   // Depth is a power of two, so wrap is a mask.
   localparam logic [PC_BITS-1:0] PC_MASK = PC_BITS'(INST_MEM_DEPTH - 1);

   state_t                 state_q, state_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [INST_BITS-1:0]   inst_q, inst_d;
   logic                   valid_q, valid_d;
   logic [PC_BITS-1:0]     pc_inc;

   assign pc_inc = (pc_q + 1'b1) & PC_MASK;

`ifdef FETCH_BRANCH_EN
   logic                   pend_q, pend_d;
   logic [PC_BITS-1:0]     tgt_q, tgt_d;
   logic [PC_BITS-1:0]     br_tgt;

   assign br_tgt = i_branch_target & PC_MASK;
`else
   logic unused_br;
   assign unused_br = ^{i_branch_valid, i_branch_target};
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
`ifdef FETCH_BRANCH_EN
         pend_q  <= 1'b0;
         tgt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
`ifdef FETCH_BRANCH_EN
         pend_q  <= pend_d;
         tgt_q   <= tgt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
`ifdef FETCH_BRANCH_EN
      pend_d  = pend_q;
      tgt_d   = tgt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            state_d = i_halt ? S_HALT : S_FETCH;
         end
         S_FETCH: begin
`ifdef FETCH_BRANCH_EN
            if (i_imem_ack) begin
               pend_d = 1'b0;
               // Any redirect (live or pending) discards the returned word.
               if (i_branch_valid) begin
                  pc_d = br_tgt;
               end else if (pend_q) begin
                  pc_d = tgt_q;
               end else begin
                  inst_d  = i_imem_data;
                  valid_d = 1'b1;
                  pc_d    = pc_inc;
                  state_d = S_HOLD;
               end
            end else if (i_branch_valid) begin
               pend_d = 1'b1;
               tgt_d  = br_tgt;
            end
`else
            if (i_imem_ack) begin
               inst_d  = i_imem_data;
               valid_d = 1'b1;
               pc_d    = pc_inc;
               state_d = S_HOLD;
            end
`endif
         end
         S_HOLD: begin
`ifdef FETCH_BRANCH_EN
            // Redirect beats a simultaneous handshake.
            if (i_branch_valid) begin
               valid_d = 1'b0;
               pc_d    = br_tgt;
               state_d = S_FETCH;
            end else if (i_inst_ready) begin
               valid_d = 1'b0;
               state_d = i_halt ? S_HALT : S_FETCH;
            end
`else
            if (i_inst_ready) begin
               valid_d = 1'b0;
               state_d = i_halt ? S_HALT : S_FETCH;
            end
`endif
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_pc         = pc_q;
   assign o_imem_req   = (state_q == S_FETCH);
   assign o_imem_addr  = pc_q;
   assign o_inst       = inst_q;
   assign o_inst_valid = valid_q;
   assign o_halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plan scenarios plus random traffic,
// checked every cycle against a behavioural fetch model.
module tb_fetch_sequencer;

   localparam int DEPTH = 64;

`ifdef FETCH_BRANCH_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_HOLD  = 2;
   localparam int M_HALT  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  pc;
   logic        req;
   logic [7:0]  addr;
   logic        ack = 1'b0;
   logic [15:0] data = '0;
   logic [15:0] inst;
   logic        inst_valid;
   logic        ready = 1'b0;
   logic        bv = 1'b0;
   logic [7:0]  bt = '0;
   logic        halt = 1'b0;
   logic        halted;

   int errs   = 0;
   int checks = 0;

   logic [15:0] mem [DEPTH];

   int m_st    = M_IDLE;
   int m_pc    = 0;
   int m_inst  = 0;
   int m_valid = 0;
   int m_pend  = 0;
   int m_tgt   = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .PC_BITS(8),
      .INST_MEM_DEPTH(DEPTH),
      .INST_BITS(16)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .o_pc(pc),
      .o_imem_req(req),
      .o_imem_addr(addr),
      .i_imem_ack(ack),
      .i_imem_data(data),
      .o_inst(inst),
      .o_inst_valid(inst_valid),
      .i_inst_ready(ready),
      .i_branch_valid(bv),
      .i_branch_target(bt),
      .i_halt(halt),
      .o_halted(halted)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: one clock edge worth of the fetch rules.
   task automatic model_edge(input bit r, input bit a, input bit rd,
                             input bit b, input int t, input bit h,
                             input int d);
      bit redir;
      redir = b && BR_EN;
      if (r) begin
         m_st = M_IDLE; m_pc = 0; m_inst = 0;
         m_valid = 0; m_pend = 0; m_tgt = 0;
      end else if (m_st == M_IDLE) begin
         m_st = h ? M_HALT : M_FETCH;
      end else if (m_st == M_FETCH) begin
         if (a) begin
            if (redir) m_pc = t % DEPTH;
            else if (m_pend != 0) m_pc = m_tgt;
            else begin
               m_inst = d; m_valid = 1;
               m_pc = (m_pc + 1) % DEPTH;
               m_st = M_HOLD;
            end
            m_pend = 0;
         end else if (redir) begin
            m_pend = 1; m_tgt = t % DEPTH;
         end
      end else if (m_st == M_HOLD) begin
         if (redir) begin
            m_valid = 0; m_pc = t % DEPTH; m_st = M_FETCH;
         end else if (rd) begin
            m_valid = 0;
            m_st = h ? M_HALT : M_FETCH;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit a, input bit rd,
                        input bit b, input int t, input bit h);
      @(negedge clk);
      rst = r; ack = a; ready = rd; bv = b; bt = 8'(t); halt = h;
      data = mem[m_pc % DEPTH];
      model_edge(r, a, rd, b, t, h, int'(data));
      @(posedge clk);
      #1;
      chk("pc", 32'(pc), 32'(m_pc));
      chk("req", 32'(req), 32'(m_st == M_FETCH));
      if (m_st == M_FETCH) chk("addr", 32'(addr), 32'(m_pc));
      chk("valid", 32'(inst_valid), 32'(m_valid));
      chk("inst", 32'(inst), 32'(m_inst));
      chk("halted", 32'(halted), 32'(m_st == M_HALT));
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);

      // Reset and start: addresses 0,1,2,3 in order.
      do_reset();
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_req", 32'(req), 32'd0);
      for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, 0, 0);
      chk("start_pc", 32'(pc), 32'd4);

      // Wrap: run sequentially up to 62, then fetch 62,63,0,1.
      for (k = 0; k < 300 && !(m_st == M_FETCH && m_pc == 62); k++)
         cycle(0, 1, 1, 0, 0, 0);
      chk("wrap_reach", 32'(k < 300), 32'd1);
      for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 0);
      chk("wrap_pc", 32'(pc), 32'd2);

      // Backpressure: 5 cycles of ready low in HOLD.
      cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
      chk("bp_valid", 32'(inst_valid), 32'd1);
      cycle(0, 0, 1, 0, 0, 0);
      chk("bp_req", 32'(req), 32'd1);

      // Redirect in HOLD at PC 5 to 0x28.
      do_reset();
      for (k = 0; k < 50 && !(m_st == M_HOLD && m_pc == 5); k++)
         cycle(0, 1, 1, 0, 0, 0);
      chk("hold5_reach", 32'(k < 50), 32'd1);
      cycle(0, 0, 1, 1, 8'h28, 0);
      if (BR_EN) chk("hold_redir", 32'(addr), 32'd40);
      cycle(0, 1, 1, 0, 0, 0);

      // Redirect in FETCH, ack delayed 3 cycles, target 0x50.
      for (k = 0; k < 50 && m_st != M_FETCH; k++)
         cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 1, 8'h50, 0);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      if (BR_EN) chk("fetch_redir", 32'(addr), 32'd16);
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);

      // Halt at a HOLD handshake, then nothing until reset.
      for (k = 0; k < 50 && m_st != M_HOLD; k++)
         cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 1);
      chk("halt_now", 32'(halted), 32'd1);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, i[0], 7, 0);

      // Reset mid-request with an ack landing during reset.
      do_reset();
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(1, 0, 1, 0, 0, 0);
      cycle(1, 1, 1, 0, 0, 0);
      chk("midrst_valid", 32'(inst_valid), 32'd0);
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      chk("midrst_addr", 32'(addr), 32'd0);

      // Random traffic.
      for (int i = 0; i < 4000; i++)
         cycle($urandom_range(99) < 2, $urandom_range(1),
               $urandom_range(99) < 60, $urandom_range(99) < 10,
               int'($urandom_range(255)), $urandom_range(99) < 3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that drives the program counter register's load path. It owns the architectural PC value, issues read requests to instruction memory, and hands fetched instructions to decode with a valid/ready handshake. It also applies sequential increment, wrap-around and branch redirects. Its `o_pc` feeds the PC register's data input every cycle.

## Interface
- `PC_BITS`, 8: PC width.
- `INST_MEM_DEPTH`, 64: instruction memory depth in words; PC wraps modulo this value (power of two, ≤ 2^PC_BITS).
- `INST_BITS`, 16: instruction word width.

Ports:
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `o_pc` out PC_BITS: current PC, registered; loaded into the PC register.
- `o_imem_req` out 1: instruction memory read request.
- `o_imem_addr` out PC_BITS: read address, equal to `o_pc` while `o_imem_req`=1.
- `i_imem_ack` in 1: read data valid this cycle.
- `i_imem_data` in INST_BITS: read data.
- `o_inst` out INST_BITS: instruction to decode.
- `o_inst_valid` out 1: `o_inst` valid.
- `i_inst_ready` in 1: decode accepts `o_inst`.
- `i_branch_valid` in 1: redirect request, single-cycle pulse.
- `i_branch_target` in PC_BITS: redirect target.
- `i_halt` in 1: stop fetching.
- `o_halted` out 1: sequencer is in HALT.

## Operation
- States are IDLE, FETCH, HOLD and HALT, all registered.
- **Reset values:** state=IDLE, `o_pc`=0, `o_imem_req`=0, `o_inst`=0, `o_inst_valid`=0, `o_halted`=0, pending-redirect flag=0.
- **IDLE:**
  - Goes to HALT if `i_halt`=1.
  - Otherwise goes to FETCH on the next edge.
- **FETCH:**
  - `o_imem_req`=1 and `o_imem_addr`=`o_pc`.
  - The address is held stable until ack.
  - On `i_imem_ack` with no redirect pending:
    - `o_inst` ← `i_imem_data`, `o_inst_valid` ← 1.
    - `o_pc` ← (`o_pc`+1) mod `INST_MEM_DEPTH`.
    - Next state is HOLD.
- **HOLD:**
  - `o_inst`/`o_inst_valid` are held stable until `i_inst_ready`=1.
  - On the handshake, `o_inst_valid` ← 0.
  - Next state is HALT if `i_halt`=1, else FETCH.
- **HALT:**
  - `o_imem_req`=0 and `o_halted`=1.
  - Exit only via `i_rst`.
- **Redirect address:** target = `i_branch_target` mod `INST_MEM_DEPTH`; upper bits are masked.
- **Redirect in FETCH without ack:**
  - Target is latched and the pending flag is set.
  - The request continues unchanged.
  - On ack: data is discarded, `o_inst_valid` stays 0, `o_pc` ← latched target, flag cleared, state stays FETCH.
- **Redirect in FETCH on the ack cycle:** ack data is discarded, `o_pc` ← target, state stays FETCH.
- **Redirect in HOLD:**
  - Flush: `o_inst_valid` ← 0 and `o_pc` ← target, next state FETCH.
  - A redirect wins over a simultaneous `i_inst_ready`; the instruction is dropped.
- **Second redirect while one is pending:** the newer target overwrites the latched one.
- `i_halt` is ignored in FETCH; it is sampled only in IDLE and at the HOLD handshake.
- **Reset mid-operation:** all state returns to reset values on the next edge, even mid-request. An outstanding memory ack after reset is ignored, because IDLE never samples ack.

## Timing
- Reset release: `o_imem_req` rises 1 cycle after the first edge with `i_rst`=0.
- Ack at edge N: `o_inst_valid`=1 and the incremented `o_pc` are visible after edge N.
- Handshake at edge N: a new `o_imem_req` is visible after edge N.
- Peak throughput is one instruction per 2 cycles, with ack in the first request cycle and ready held high.
- Redirect at edge N in HOLD: `o_imem_addr`=target after edge N.

## Configuration
- Macro: `FETCH_BRANCH_EN`.
- **Defined:** redirect logic as specified above.
- **Undefined:**
  - `i_branch_valid`/`i_branch_target` are ignored.
  - Pending-flag and target registers are not built.
  - PC is purely sequential with wrap.
  - All ports remain present.

## Test plan
- **Reset/start:** assert `i_rst` 2 cycles, release, ack every request, ready high.
  - Required: addresses 0,1,2,3 and `o_inst` matches memory contents.
- **Wrap:** run from 62 with `INST_MEM_DEPTH`=64.
  - Required: fetch addresses 62,63,0,1.
- **Backpressure:** hold `i_inst_ready`=0 for 5 cycles.
  - Required: `o_inst` stable, `o_inst_valid`=1, no `o_imem_req`.
  - On ready: next address requested.
- **Redirect:**
  - In HOLD at PC 5, target 0x28: instruction flushed, next request at 40.
  - In FETCH with ack delayed 3 cycles, target 0x50: first ack data dropped, next request at 16 (0x50 mod 64).
- **Halt:** `i_halt`=1 at a HOLD handshake.
  - Required: `o_halted`=1 next cycle and no further requests until `i_rst`.
- **Reset mid-request:** assert `i_rst` while `o_imem_req`=1, then ack during reset.
  - Required: all outputs at reset values and the first post-reset request at address 0.
